// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment table and FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba patterns; element i is the glyph for hex digit i.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, // F
    7'b0000110, // E
    7'b0100001, // d
    7'b1000110, // C
    7'b0000011, // b
    7'b0001000, // A
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin digit scanner with blanking gaps and a frame-synchronous
// shadow buffer fed by a valid/ready handshake.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  output logic                    upd_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              outSeg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned IW   = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] T_DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  state_t                        r_state;
  logic [IW-1:0]                 r_idx;
  logic [TW-1:0]                 r_timer;
  logic                          r_slot_en;
  logic [NUM_DIGITS-1:0][3:0]    r_shadow;
  logic [NUM_DIGITS-1:0][3:0]    r_active;
  logic                          r_pending;
  logic [6:0]                    r_seg;
  logic [NUM_DIGITS-1:0]         r_sel;
  logic                          r_frame_done;

  state_t                        w_state_nxt;
  logic [IW-1:0]                 w_idx_nxt;
  logic [TW-1:0]                 w_timer_nxt;
  logic                          w_slot_en_nxt;
  logic                          w_lit;
  logic [3:0]                    w_nibble;
  logic [6:0]                    w_dec;
  logic [6:0]                    w_seg_nxt;
  logic [NUM_DIGITS-1:0]         w_sel_nxt;
  logic                          w_fd_nxt;

  seg_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_timer_nxt   = r_timer + TW'(1);
    w_slot_en_nxt = r_slot_en;
    case (r_state)
      ST_BLANK: begin
        if (r_timer == T_BLANK_LAST) begin
          w_state_nxt   = ST_ON;
          w_timer_nxt   = '0;
          // Enable is latched at slot entry so a mid-slot change never flickers a digit.
          w_slot_en_nxt = digit_en[r_idx];
        end
      end
      ST_ON: begin
        if (r_timer == T_DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_timer_nxt = '0;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_timer_nxt = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with r_state.
    w_nibble  = r_active[w_idx_nxt];
    w_lit     = (w_state_nxt == ST_ON) && w_slot_en_nxt;
    w_seg_nxt = w_lit ? w_dec : SEG_BLANK;
    w_sel_nxt = '1;
    if (w_lit) w_sel_nxt[w_idx_nxt] = 1'b0;
    w_fd_nxt  = (w_state_nxt == ST_ON) && (w_idx_nxt == IDX_LAST) && (w_timer_nxt == T_DWELL_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_BLANK;
      r_idx        <= '0;
      r_timer      <= '0;
      r_slot_en    <= 1'b0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_sel        <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_timer      <= w_timer_nxt;
      r_slot_en    <= w_slot_en_nxt;
      r_seg        <= w_seg_nxt;
      r_sel        <= w_sel_nxt;
      r_frame_done <= w_fd_nxt;
      // Transfer and commit are exclusive: ready is low whenever a commit is possible.
      if (upd_valid && !r_pending) begin
        r_shadow  <= upd_value;
        r_pending <= 1'b1;
      end else if (r_frame_done && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  assign upd_ready  = !r_pending;
  assign outSeg     = r_seg;
  assign digit_sel  = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=2 (24-cycle frames).
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        upd_valid;
  logic [15:0] upd_value;
  logic        upd_ready;
  logic [3:0]  digit_en;
  logic [6:0]  outSeg;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .upd_valid  (upd_valid),
    .upd_value  (upd_value),
    .upd_ready  (upd_ready),
    .digit_en   (digit_en),
    .outSeg     (outSeg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Expected outputs for the current cycle: slot = 2 blank + 4 lit cycles per digit.
  task automatic check_now(input logic [15:0] act, input logic [3:0] en);
    int k, pos, dig;
    logic [3:0] nib;
    logic [3:0] esel;
    logic [6:0] eseg;
    k    = cyc % 24;
    pos  = k % 6;
    dig  = k / 6;
    nib  = act[4*dig +: 4];
    esel = 4'b1111;
    eseg = 7'b1111111;
    if (pos >= 2 && en[dig]) begin
      esel[dig] = 1'b0;
      eseg      = hex7(nib);
    end
    chk("digit_sel", {12'd0, digit_sel}, {12'd0, esel});
    chk("outSeg", {9'd0, outSeg}, {9'd0, eseg});
    chk("frame_done", {15'd0, frame_done}, {15'd0, (k == 23)});
  endtask

  task automatic run_to(input int target, input logic [15:0] act, input logic [3:0] en);
    while (cyc < target) begin
      check_now(act, en);
      step();
    end
  endtask

  task automatic offer(input logic [15:0] val, input logic [15:0] act, input logic [3:0] en);
    check_now(act, en);
    chk("ready_before_offer", {15'd0, upd_ready}, 16'd1);
    upd_valid = 1'b1;
    upd_value = val;
    step();
    upd_valid = 1'b0;
    chk("ready_after_accept", {15'd0, upd_ready}, 16'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_digit_sel", {12'd0, digit_sel}, 16'h000F);
    chk("rst_outSeg", {9'd0, outSeg}, 16'h007F);
    chk("rst_frame_done", {15'd0, frame_done}, 16'd0);
    chk("rst_upd_ready", {15'd0, upd_ready}, 16'd1);
  endtask

  initial begin
    RST       = 1'b1;
    upd_valid = 1'b0;
    upd_value = 16'h0000;
    digit_en  = 4'hF;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    RST = 1'b0;
    cyc = 0;

    // Update accepted at cycle 5, second offer held under back-pressure from cycle 10.
    run_to(5, 16'h0000, 4'hF);
    offer(16'h3210, 16'h0000, 4'hF);
    run_to(10, 16'h0000, 4'hF);
    upd_valid = 1'b1;
    upd_value = 16'hFFFF;
    while (cyc < 24) begin
      check_now(16'h0000, 4'hF);
      chk("ready_while_pending", {15'd0, upd_ready}, 16'd0);
      step();
    end
    chk("ready_after_commit", {15'd0, upd_ready}, 16'd1);
    check_now(16'h3210, 4'hF);
    step();
    upd_valid = 1'b0;
    chk("ready_held_accept", {15'd0, upd_ready}, 16'd0);
    run_to(48, 16'h3210, 4'hF);
    chk("ready_second_commit", {15'd0, upd_ready}, 16'd1);
    run_to(72, 16'hFFFF, 4'hF);

    // Digit 2 masked for a whole frame.
    digit_en = 4'b1011;
    run_to(96, 16'hFFFF, 4'b1011);
    digit_en = 4'hF;

    // Mid-frame reset with a pending update that must be discarded.
    offer(16'h5555, 16'hFFFF, 4'hF);
    run_to(111, 16'hFFFF, 4'hF);
    chk("ready_pending_pre_rst", {15'd0, upd_ready}, 16'd0);
    RST = 1'b1;
    step();
    check_reset_outputs();
    RST = 1'b0;
    cyc = 0;
    run_to(48, 16'h0000, 4'hF);

    // Decode sweep across frame wraps.
    offer(16'hBA98, 16'h0000, 4'hF);
    run_to(72, 16'h0000, 4'hF);
    offer(16'hFEDC, 16'h0000, 4'hF);
    run_to(96, 16'hBA98, 4'hF);
    run_to(120, 16'hFEDC, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
